fetch_ctrl: RTL and testbench

Sequencing controller for the dual-issue fetch unit. Arbitrates PC redirect sources (execute-stage misprediction correction, decode-stage jump-register) against pipeline-hazard stalls. Drives the fetch unit's PC hold, redirect-enable/address and IF/ID flush controls, including the refill bubble caused by the synchronous instruction memory. Also runs a stall watchdog that flags a hung pipeline.

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: arbitrates redirect sources against hazard stalls and runs a stall watchdog.
// Optional perf counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int STALL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_stall,
  input  logic              correct_req,
  input  logic [ADDR_W-1:0] correct_addr,
  input  logic              jr_req,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic              pc_hold,
  output logic              redirect_en,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              flush_if,
  output logic              flush_id,
  output logic              stall_timeout,
  output logic [15:0]       redirect_count,
  output logic [15:0]       stall_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_REFILL   = 2'd2
  } state_t;

  localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_kind_corr;
  logic [7:0]        r_wd_cnt;
  logic [7:0]        w_wd_next;
  logic              r_timeout;
  logic              w_acc_corr;
  logic              w_acc_jr;
  logic              w_accept;

  // Requests are valid-only pulses; "ready" is the accept term below. A correction is
  // always taken; a jr is taken only with no correction and no stall, otherwise decode re-presents it.
  assign w_acc_corr = correct_req;
  assign w_acc_jr   = jr_req & ~correct_req & ~hazard_stall;
  assign w_accept   = w_acc_corr | w_acc_jr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_addr_q    <= '0;
      r_kind_corr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr_q    <= w_acc_corr ? correct_addr : jr_addr;
        r_kind_corr <= w_acc_corr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    pc_hold      = hazard_stall;
    redirect_en  = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      ST_REDIRECT: begin
        pc_hold      = 1'b0;
        redirect_en  = 1'b1;
        flush_if     = 1'b1;
        flush_id     = r_kind_corr;
        w_state_next = ST_REFILL;
      end
      ST_REFILL: begin
        // Synchronous imem returns the old fetch this cycle; squash it.
        flush_if     = 1'b1;
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
    if (w_accept) w_state_next = ST_REDIRECT;
  end

  assign redirect_addr = r_addr_q;
  assign dbg_state     = r_state;

  assign w_wd_next = !pc_hold ? 8'd0 :
                     (r_wd_cnt == STALL_MAX_C) ? r_wd_cnt : r_wd_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt  <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_next;
      if (w_wd_next == STALL_MAX_C) r_timeout <= 1'b1;
    end
  end

  assign stall_timeout = r_timeout;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] r_redirect_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_redirect_cnt <= 16'd0;
      r_stall_cnt    <= 16'd0;
    end else begin
      if (redirect_en && r_redirect_cnt != 16'hFFFF) r_redirect_cnt <= r_redirect_cnt + 16'd1;
      if (pc_hold && r_stall_cnt != 16'hFFFF)        r_stall_cnt    <= r_stall_cnt + 16'd1;
    end
  end

  assign redirect_count = r_redirect_cnt;
  assign stall_count    = r_stall_cnt;
`else
  assign redirect_count = 16'd0;
  assign stall_count    = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed test-plan steps then random traffic, checked against a
// cycle-countdown reference model and a redirect-target queue.
module tb_fetch_ctrl;
  localparam int ADDR_W    = 10;
  localparam int STALL_MAX = 255;

  logic              clk;
  logic              rst;
  logic              hazard_stall;
  logic              correct_req;
  logic [ADDR_W-1:0] correct_addr;
  logic              jr_req;
  logic [ADDR_W-1:0] jr_addr;
  logic              pc_hold;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_addr;
  logic              flush_if;
  logic              flush_id;
  logic              stall_timeout;
  logic [15:0]       redirect_count;
  logic [15:0]       stall_count;
  logic [1:0]        dbg_state;

  fetch_ctrl #(.ADDR_W(ADDR_W), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
    .correct_req(correct_req), .correct_addr(correct_addr),
    .jr_req(jr_req), .jr_addr(jr_addr),
    .pc_hold(pc_hold), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .flush_if(flush_if), .flush_id(flush_id), .stall_timeout(stall_timeout),
    .redirect_count(redirect_count), .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: cycles of redirect work left (2 = redirect cycle, 1 = refill cycle)
  int                m_left;
  logic [ADDR_W-1:0] m_tgt;
  logic              m_corr;
  int                m_run;
  logic              m_to;
  int                m_rc;
  int                m_sc;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_tgt = '0; m_corr = 1'b0;
    m_run = 0; m_to = 1'b0; m_rc = 0; m_sc = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input logic hs);
    logic [ADDR_W-1:0] got;
    chk("pc_hold",       32'(pc_hold),       32'(hs && m_left != 2));
    chk("redirect_en",   32'(redirect_en),   32'(m_left == 2));
    chk("redirect_addr", 32'(redirect_addr), 32'(m_tgt));
    chk("flush_if",      32'(flush_if),      32'(m_left > 0));
    chk("flush_id",      32'(flush_id),      32'(m_left == 2 && m_corr));
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef FETCH_CTRL_PERF_EN
    chk("redirect_count", 32'(redirect_count), 32'(m_rc));
    chk("stall_count",    32'(stall_count),    32'(m_sc));
`else
    chk("redirect_count", 32'(redirect_count), 32'd0);
    chk("stall_count",    32'(stall_count),    32'd0);
`endif
    if (m_left == 2) exp_q.push_back(m_tgt);
    if (redirect_en === 1'b1) begin
      chk("redirect_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("redirect_q_target", 32'(redirect_addr), 32'(got));
      end
    end
  endtask

  task automatic model_edge(input logic hs, input logic cr, input logic [ADDR_W-1:0] ca,
                            input logic jr, input logic [ADDR_W-1:0] ja);
    logic hold;
    hold = hs && m_left != 2;
    if (hold) begin
      m_run++;
      if (m_run >= STALL_MAX) m_to = 1'b1;
    end else begin
      m_run = 0;
    end
    if (m_left == 2 && m_rc < 65535) m_rc++;
    if (hold && m_sc < 65535) m_sc++;
    if (cr) begin
      m_tgt = ca; m_corr = 1'b1; m_left = 2;
    end else if (jr && !hs) begin
      m_tgt = ja; m_corr = 1'b0; m_left = 2;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input logic hs, input logic cr, input logic [ADDR_W-1:0] ca,
                      input logic jr, input logic [ADDR_W-1:0] ja);
    @(negedge clk);
    hazard_stall = hs; correct_req = cr; correct_addr = ca; jr_req = jr; jr_addr = ja;
    #1;
    check_outputs(hs);
    @(posedge clk);
    model_edge(hs, cr, ca, jr, ja);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    hazard_stall = 1'b0; correct_req = 1'b1; correct_addr = 10'h2AA;
    jr_req = 1'b0; jr_addr = '0;
    model_reset();
    #1;
    chk("rst_redirect_en", 32'(redirect_en), 32'd0);
    chk("rst_flush_if",    32'(flush_if),    32'd0);
    chk("rst_flush_id",    32'(flush_id),    32'd0);
    chk("rst_addr",        32'(redirect_addr), 32'd0);
    chk("rst_pc_hold",     32'(pc_hold),     32'd0);
    chk("rst_timeout",     32'(stall_timeout), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_redirect_en", 32'(redirect_en), 32'd0);
    chk("rst_hold_counts", 32'({redirect_count, stall_count}), 32'd0);
    rst = 1'b1;
    correct_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hazard_stall = 1'b0; correct_req = 1'b0; correct_addr = '0; jr_req = 1'b0; jr_addr = '0;
    model_reset();
    #2;
    do_reset();

    // pc_hold follows hazard_stall in RUN
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);

    // correction to 12A: redirect, refill, run
    step(1'b0, 1'b1, 10'h12A, 1'b0, '0);
    #2;
    chk("corr_redirect_en", 32'(redirect_en), 32'd1);
    chk("corr_addr",        32'(redirect_addr), 32'h12A);
    chk("corr_flush_id",    32'(flush_id), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    chk("refill_flush_if",  32'(flush_if), 32'd1);
    chk("refill_redirect",  32'(redirect_en), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    chk("run_flush_if",     32'(flush_if), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0);

    // jr held off by a stall, then taken
    step(1'b1, 1'b0, '0, 1'b1, 10'h040);
    #2;
    chk("jr_stalled_no_redirect", 32'(redirect_en), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 10'h040);
    #2;
    chk("jr_redirect_en", 32'(redirect_en), 32'd1);
    chk("jr_addr",        32'(redirect_addr), 32'h040);
    chk("jr_flush_id",    32'(flush_id), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);

    // simultaneous correction and jr, then a new correction during refill
    step(1'b0, 1'b1, 10'h3FF, 1'b1, 10'h010);
    #2;
    chk("both_addr", 32'(redirect_addr), 32'h3FF);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 10'h005, 1'b0, '0);
    #2;
    chk("refill_restart_en",   32'(redirect_en), 32'd1);
    chk("refill_restart_addr", 32'(redirect_addr), 32'h005);
    step(1'b1, 1'b1, 10'h155, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);

    // asynchronous reset in the middle of a redirect
    step(1'b0, 1'b1, 10'h0F0, 1'b0, '0);
    do_reset();

    // watchdog
    for (int i = 0; i < STALL_MAX - 1; i++) step(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    chk("wd_below_max", 32'(stall_timeout), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    chk("wd_at_max", 32'(stall_timeout), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    chk("wd_sticky", 32'(stall_timeout), 32'd1);

    // perf counters: 3 corrections and 7 stall cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 10'(i * 100 + 7), 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
    end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_redirects", 32'(redirect_count), 32'd3);
    chk("perf_stalls",    32'(stall_count),    32'd7);
`else
    chk("perf_redirects_off", 32'(redirect_count), 32'd0);
    chk("perf_stalls_off",    32'(stall_count),    32'd0);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), 10'($urandom_range(0, 1023)),
           ($urandom_range(0, 5) == 0), 10'($urandom_range(0, 1023)));
    end
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("redirect_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "time limit");
  end
endmodule
